// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin arbiter with packet-level grant locking and ready qualification.
// Optional lock watchdog (timeout_err port) is built when ARB_LOCK_TIMEOUT_EN is defined.
module wrr_packet_arbiter #(
    parameter int ARBITER_WIDTH = 8,
    parameter int WEIGHT_WIDTH  = 4,
    parameter int LOCK_TIMEOUT  = 256
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [ARBITER_WIDTH-1:0]              request,
    input  logic [ARBITER_WIDTH*WEIGHT_WIDTH-1:0] weight,
    input  logic                                  last,
    input  logic                                  ready,
    output logic [ARBITER_WIDTH-1:0]              grant,
    output logic [$clog2(ARBITER_WIDTH)-1:0]      grant_bin,
`ifdef ARB_LOCK_TIMEOUT_EN
    output logic                                  timeout_err,
`endif
    output logic                                  any_grant
);

    localparam int IDX_W = $clog2(ARBITER_WIDTH);

    logic                    locked;
    logic [IDX_W-1:0]        owner;
    logic [IDX_W-1:0]        ptr;
    logic                    sticky;
    logic [WEIGHT_WIDTH-1:0] cnt;

    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_vld;
    logic                    xfer;
    logic                    wd_hit;

    // A zero weight behaves as weight 1 so every requester gets at least one packet.
    logic [ARBITER_WIDTH-1:0][WEIGHT_WIDTH-1:0] w_eff;
    for (genvar i = 0; i < ARBITER_WIDTH; i++) begin : g_weff
        assign w_eff[i] = (weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0)
                        ? weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
                        : WEIGHT_WIDTH'(1);
    end

    always_comb begin
        logic [IDX_W-1:0] rr_idx;
        rr_idx  = '0;
        sel_idx = '0;
        sel_vld = 1'b0;
        if (locked) begin
            sel_idx = owner;
            sel_vld = request[owner];
        end else if (sticky && request[owner]) begin
            sel_idx = owner;
            sel_vld = 1'b1;
        end else begin
            // Scan from farthest to nearest so the nearest set request after ptr wins.
            for (int k = ARBITER_WIDTH; k >= 1; k--) begin
                rr_idx = IDX_W'((int'(ptr) + k) % ARBITER_WIDTH);
                if (request[rr_idx]) begin
                    sel_idx = rr_idx;
                    sel_vld = 1'b1;
                end
            end
        end
    end

    assign grant     = sel_vld ? (ARBITER_WIDTH'(1) << sel_idx) : '0;
    assign grant_bin = sel_vld ? sel_idx : '0;
    assign any_grant = sel_vld;
    assign xfer      = sel_vld & ready;

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int WD_W = $clog2(LOCK_TIMEOUT) + 1;
    logic [WD_W-1:0] wd_cnt;

    // Fires on the LOCK_TIMEOUT-th consecutive locked cycle without a transfer.
    assign wd_hit      = locked && !xfer && (wd_cnt == WD_W'(LOCK_TIMEOUT - 1));
    assign timeout_err = wd_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wd_cnt <= '0;
        else if (!locked || xfer || wd_hit)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + WD_W'(1);
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked <= 1'b0;
            owner  <= '0;
            ptr    <= IDX_W'(ARBITER_WIDTH - 1);
            sticky <= 1'b0;
            cnt    <= '0;
        end else if (xfer) begin
            owner <= sel_idx;
            if (!last) begin
                locked <= 1'b1;
            end else begin
                locked <= 1'b0;
                ptr    <= sel_idx;
                if (sel_idx == owner && sticky) begin
                    cnt    <= cnt - WEIGHT_WIDTH'(1);
                    sticky <= (cnt - WEIGHT_WIDTH'(1)) != '0;
                end else begin
                    cnt    <= w_eff[sel_idx] - WEIGHT_WIDTH'(1);
                    sticky <= w_eff[sel_idx] > WEIGHT_WIDTH'(1);
                end
            end
        end else if (wd_hit) begin
            // Release a stuck owner and rotate priority past it.
            locked <= 1'b0;
            sticky <= 1'b0;
            ptr    <= owner;
        end
    end

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Scoreboard bench for wrr_packet_arbiter: expectations queued at drive time, checked at negedge.
// Timeout scenario runs only when ARB_LOCK_TIMEOUT_EN is defined.
module tb_wrr_packet_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  request = '0;
    logic [31:0] weight = {8{4'd1}};
    logic        last = 1'b1;
    logic        ready = 1'b1;
    logic [7:0]  grant;
    logic [2:0]  grant_bin;
    logic        any_grant;
    logic        timeout_err;

    always #5 clk = ~clk;

`ifdef ARB_LOCK_TIMEOUT_EN
    wrr_packet_arbiter #(.ARBITER_WIDTH(8), .WEIGHT_WIDTH(4), .LOCK_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .request(request), .weight(weight),
        .last(last), .ready(ready), .grant(grant), .grant_bin(grant_bin),
        .timeout_err(timeout_err), .any_grant(any_grant));
`else
    assign timeout_err = 1'b0;
    wrr_packet_arbiter #(.ARBITER_WIDTH(8), .WEIGHT_WIDTH(4), .LOCK_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .request(request), .weight(weight),
        .last(last), .ready(ready), .grant(grant), .grant_bin(grant_bin),
        .any_grant(any_grant));
`endif

    typedef struct {
        int         id;
        logic [7:0] g;
        logic [2:0] b;
        logic       to;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] oh2bin(input logic [7:0] oh);
        logic [2:0] b;
        b = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) b = 3'(i);
        return b;
    endfunction

    // One cycle: drive inputs just after posedge and queue what the DUT must show.
    task automatic cyc(input logic [7:0] req, input logic lst, input logic rdy,
                       input logic [7:0] eg, input logic eto = 1'b0, input logic rn = 1'b1);
        exp_t x;
        @(posedge clk);
        #1;
        reset_n = rn;
        request = req;
        last    = lst;
        ready   = rdy;
        x.id = n_cyc; x.g = eg; x.b = oh2bin(eg); x.to = eto;
        sb.push_back(x);
        n_cyc++;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk($sformatf("grant@%0d", e.id), 32'(grant), 32'(e.g));
            chk($sformatf("grant_bin@%0d", e.id), 32'(grant_bin), 32'(e.b));
            chk($sformatf("any_grant@%0d", e.id), 32'(any_grant), 32'(|e.g));
`ifdef ARB_LOCK_TIMEOUT_EN
            chk($sformatf("timeout_err@%0d", e.id), 32'(timeout_err), 32'(e.to));
`endif
        end
    end

    initial begin
        // reset: idle outputs, and requester 0 has priority while still in reset
        cyc(8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc(8'hFF, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);

        // plain rotation 0..7,0
        for (int i = 0; i < 9; i++)
            cyc(8'hFF, 1'b1, 1'b1, 8'h01 << (i % 8));

        // 4-flit packet from requester 2 blocks requester 5
        for (int i = 0; i < 4; i++)
            cyc(8'h24, (i == 3), 1'b1, 8'h04);
        cyc(8'h20, 1'b1, 1'b1, 8'h20);

        // weight 3 on requester 3; prime ptr at 0 first
        weight[15:12] = 4'd3;
        cyc(8'h01, 1'b1, 1'b1, 8'h01);
        for (int i = 0; i < 8; i++)
            cyc(8'h09, 1'b1, 1'b1, ((i % 4) == 3) ? 8'h01 : 8'h08);

        // backpressure mid-packet; stalled tail must not unlock
        cyc(8'h02, 1'b0, 1'b1, 8'h02);
        for (int i = 0; i < 5; i++)
            cyc(8'h03, 1'b1, 1'b0, 8'h02);
        cyc(8'h03, 1'b0, 1'b1, 8'h02);
        cyc(8'h03, 1'b1, 1'b1, 8'h02);
        cyc(8'h03, 1'b1, 1'b1, 8'h01);

        // lock on 6, owner drops request (lock held), resumes, then reset mid-packet
        cyc(8'h40, 1'b0, 1'b1, 8'h40);
        cyc(8'h01, 1'b0, 1'b1, 8'h00);
        cyc(8'h41, 1'b0, 1'b1, 8'h40);
        cyc(8'h41, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        cyc(8'h41, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        cyc(8'h41, 1'b1, 1'b1, 8'h01);

`ifdef ARB_LOCK_TIMEOUT_EN
        // requester 4 locks and vanishes; watchdog frees the port for 7
        cyc(8'h10, 1'b0, 1'b1, 8'h10);
        for (int i = 0; i < 16; i++)
            cyc(8'h80, 1'b0, 1'b1, 8'h00, (i == 15));
        cyc(8'h80, 1'b1, 1'b1, 8'h80);
`endif

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
